seg7_frame_capture: RTL and testbench

Reads a multiplexed 7-segment display bus (segment lines plus per-digit select) and converts it back into a packed multi-digit BCD word. Each digit's pattern must be stable for a programmable number of consecutive samples before it is accepted. Once every digit of a frame has been captured, the word is presented on a valid/ready output port. The block sits on the monitor/loopback side of the display path: it checks or re-reads whatever the segment driver is emitting.

---
 rtl/seg7_frame_capture_if.sv | 25 ++
 rtl/seg7_frame_capture.sv | 163 ++++++++++++++++
 tb/tb_seg7_frame_capture.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_frame_capture_if.sv
// Bus bundle for seg7_frame_capture: multiplexed 7-segment input side
// plus the valid/ready frame output and the error/overrun pulses.
interface seg7_frame_capture_if #(
    parameter int DIGITS = 4
);
    logic                  sample;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     dig_sel;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  out_valid;
    logic                  out_ready;
    logic                  err;
    logic                  overrun;

    // master drives the display bus and consumes frames; slave is the capture block
    modport master (
        output sample, seg, dig_sel, out_ready,
        input  bcd_out, out_valid, err, overrun
    );

    modport slave (
        input  sample, seg, dig_sel, out_ready,
        output bcd_out, out_valid, err, overrun
    );
endinterface

// File: rtl/seg7_frame_capture.sv
// Re-reads a multiplexed 7-segment bus into a packed BCD frame with per-digit
// stability filtering. Define SEG7_BLANK_EN to accept the all-off pattern as blank (4'hF).
module seg7_frame_capture #(
    parameter int DIGITS = 4,
    parameter int STABLE = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_frame_capture_if.slave  bus
);

    localparam int              IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [3:0]      STABLE_C = 4'(STABLE);
    localparam logic [DIGITS-1:0] ONE    = DIGITS'(1);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } out_state_t;

    // Returns {legal, value} for a segment pattern ordered a..g.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] d;
        d = 5'b0_0000;
        case (s)
            7'b1111110: d = {1'b1, 4'd0};
            7'b0110000: d = {1'b1, 4'd1};
            7'b1101101: d = {1'b1, 4'd2};
            7'b1111001: d = {1'b1, 4'd3};
            7'b0110011: d = {1'b1, 4'd4};
            7'b1011011: d = {1'b1, 4'd5};
            7'b1011111: d = {1'b1, 4'd6};
            7'b1110000: d = {1'b1, 4'd7};
            7'b1111111: d = {1'b1, 4'd8};
            7'b1111011: d = {1'b1, 4'd9};
`ifdef SEG7_BLANK_EN
            7'b0000000: d = {1'b1, 4'hF};
`else
            7'b0000000: d = 5'b0_0000;
`endif
            default:    d = 5'b0_0000;
        endcase
        return d;
    endfunction

    logic [IDX_W-1:0]     r_last_idx;
    logic [6:0]           r_last_seg;
    logic [3:0]           r_stab_cnt;
    logic [4*DIGITS-1:0]  r_frame;
    logic [DIGITS-1:0]    r_got;
    logic [4*DIGITS-1:0]  r_bcd;
    logic                 r_err;
    logic                 r_overrun;
    out_state_t           r_state;

    logic                 w_sel_any;
    logic                 w_onehot;
    logic                 w_multi;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_same;
    logic [3:0]           w_cnt_next;
    logic                 w_accept;
    logic [4:0]           w_dec;
    logic                 w_legal;
    logic [DIGITS-1:0]    w_got_set;
    logic                 w_complete;
    logic [4*DIGITS-1:0]  w_frame_next;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_idx = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (bus.dig_sel[k]) w_idx = k[IDX_W-1:0];
        end
    end

    assign w_sel_any = |bus.dig_sel;
    assign w_onehot  = w_sel_any && ((bus.dig_sel & (bus.dig_sel - ONE)) == '0);
    assign w_multi   = w_sel_any && !w_onehot;

    assign w_same     = w_onehot && (w_idx == r_last_idx) && (bus.seg == r_last_seg);
    assign w_cnt_next = !w_same                  ? 4'd1 :
                        (r_stab_cnt == STABLE_C) ? STABLE_C :
                                                   r_stab_cnt + 4'd1;

    // Accept only on the transition into STABLE, never while already saturated.
    assign w_accept = bus.sample && w_onehot && (w_cnt_next == STABLE_C)
                      && !(w_same && (r_stab_cnt == STABLE_C));

    assign w_dec      = decode(bus.seg);
    assign w_legal    = w_dec[4];
    assign w_got_set  = r_got | (ONE << w_idx);
    assign w_complete = w_accept && w_legal && (w_got_set == '1);

    always_comb begin
        w_frame_next = r_frame;
        if (w_accept && w_legal) w_frame_next[4*w_idx +: 4] = w_dec[3:0];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_idx <= '0;
            r_last_seg <= '0;
            r_stab_cnt <= '0;
            r_frame    <= '0;
            r_got      <= '0;
            r_bcd      <= '0;
            r_err      <= 1'b0;
            r_overrun  <= 1'b0;
            r_state    <= S_EMPTY;
        end else begin
            r_err     <= 1'b0;
            r_overrun <= 1'b0;

            if (bus.sample && w_multi) begin
                r_err      <= 1'b1;
                r_stab_cnt <= '0;
                r_got      <= '0;
            end else if (bus.sample && w_onehot) begin
                r_stab_cnt <= w_cnt_next;
                if (!w_same) begin
                    r_last_idx <= w_idx;
                    r_last_seg <= bus.seg;
                end
                if (w_accept) begin
                    if (w_legal) begin
                        r_frame <= w_frame_next;
                        r_got   <= w_complete ? '0 : w_got_set;
                    end else begin
                        r_err <= 1'b1;
                        r_got <= '0;
                    end
                end
            end

            // Output stage: a completed frame either loads or, under backpressure, is dropped.
            case (r_state)
                S_EMPTY: begin
                    if (w_complete) begin
                        r_bcd   <= w_frame_next;
                        r_state <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_complete) begin
                        if (bus.out_ready) r_bcd     <= w_frame_next;
                        else               r_overrun <= 1'b1;
                    end else if (bus.out_ready) begin
                        r_state <= S_EMPTY;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign bus.bcd_out   = r_bcd;
    assign bus.out_valid = (r_state == S_FULL);
    assign bus.err       = r_err;
    assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_seg7_frame_capture.sv
// Directed bench for seg7_frame_capture with DIGITS=4, STABLE=3.
// Honours SEG7_BLANK_EN the same way as the design.
module tb_seg7_frame_capture;

    localparam logic [6:0] P0 = 7'b1111110;
    localparam logic [6:0] P1 = 7'b0110000;
    localparam logic [6:0] P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001;
    localparam logic [6:0] P4 = 7'b0110011;
    localparam logic [6:0] P5 = 7'b1011011;
    localparam logic [6:0] P6 = 7'b1011111;
    localparam logic [6:0] P7 = 7'b1110000;
    localparam logic [6:0] P8 = 7'b1111111;
    localparam logic [6:0] P9 = 7'b1111011;
    localparam logic [6:0] PBAD   = 7'b1000001;
    localparam logic [6:0] PBLANK = 7'b0000000;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   err_cnt;
    int   ovr_cnt;

    seg7_frame_capture_if #(.DIGITS(4)) ifc ();

    seg7_frame_capture #(.DIGITS(4), .STABLE(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (ifc.err)     err_cnt = err_cnt + 1;
        if (ifc.overrun) ovr_cnt = ovr_cnt + 1;
    end

    task automatic step(input logic smp, input logic [3:0] sel, input logic [6:0] sg);
        ifc.sample  = smp;
        ifc.dig_sel = sel;
        ifc.seg     = sg;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'b0000, 7'b0);
    endtask

    task automatic scan_digit(input int k, input logic [6:0] pat, input int n);
        for (int i = 0; i < n; i++) step(1'b1, 4'(1 << k), pat);
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        ifc.out_ready = 1'b1;
        step(1'b1, 4'b0001, P1);
        step(1'b1, 4'b0001, P1);
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ifc.out_valid); end
        total++; if (ifc.bcd_out !== 16'h0000) begin bad++; $display("FAIL reset_bcd: got %h want 0000", ifc.bcd_out); end
        total++; if ({ifc.err, ifc.overrun} !== 2'b00) begin bad++; $display("FAIL reset_pulses: got %b want 00", {ifc.err, ifc.overrun}); end
        total++; if (dut.r_got !== 4'b0000) begin bad++; $display("FAIL reset_got: got %b want 0000", dut.r_got); end
        rst_n = 1'b1;
        idle(3);
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL reset_after_valid: got %b want 0", ifc.out_valid); end
    endtask

    task automatic test_basic_scan;
        ifc.out_ready = 1'b1;
        scan_digit(3, P1, 3);
        scan_digit(2, P2, 3);
        scan_digit(1, P3, 3);
        scan_digit(0, P4, 2);
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid: got %b want 0", ifc.out_valid); end
        scan_digit(0, P4, 1);
        total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", ifc.out_valid); end
        total++; if (ifc.bcd_out !== 16'h1234) begin bad++; $display("FAIL basic_bcd: got %h want 1234", ifc.bcd_out); end
        idle(1);
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_fall: got %b want 0", ifc.out_valid); end
    endtask

    task automatic test_glitch;
        int e0;
        e0 = err_cnt;
        ifc.out_ready = 1'b1;
        scan_digit(0, P7, 2);
        scan_digit(0, P1, 1);
        idle(1);
        total++; if (dut.r_got[0] !== 1'b0) begin bad++; $display("FAIL glitch_no_capture: got %b want 0", dut.r_got[0]); end
        scan_digit(0, P1, 2);
        total++; if (dut.r_got !== 4'b0001) begin bad++; $display("FAIL glitch_capture: got %b want 0001", dut.r_got); end
        scan_digit(1, P8, 3);
        scan_digit(2, P9, 3);
        scan_digit(3, P0, 3);
        total++; if (ifc.bcd_out !== 16'h0981) begin bad++; $display("FAIL glitch_frame: got %h want 0981", ifc.bcd_out); end
        idle(1);
        total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL glitch_err: got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_illegal;
        int e0;
        ifc.out_ready = 1'b1;
        scan_digit(1, P5, 3);
        total++; if (dut.r_got !== 4'b0010) begin bad++; $display("FAIL illegal_pre_got: got %b want 0010", dut.r_got); end
        e0 = err_cnt;
        scan_digit(0, PBAD, 4);
        idle(1);
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL illegal_pattern_err: got %0d want 1", err_cnt - e0); end
        total++; if (dut.r_got !== 4'b0000) begin bad++; $display("FAIL illegal_got_clear: got %b want 0000", dut.r_got); end
        step(1'b1, 4'b0011, P1);
        total++; if (ifc.err !== 1'b1) begin bad++; $display("FAIL illegal_sel_err: got %b want 1", ifc.err); end
        idle(1);
        total++; if (ifc.err !== 1'b0) begin bad++; $display("FAIL illegal_sel_pulse: got %b want 0", ifc.err); end
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL illegal_valid: got %b want 0", ifc.out_valid); end
    endtask

    task automatic test_backpressure;
        int o0;
        ifc.out_ready = 1'b0;
        o0 = ovr_cnt;
        scan_digit(3, P1, 3);
        scan_digit(2, P2, 3);
        scan_digit(1, P3, 3);
        scan_digit(0, P4, 3);
        total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL bp_first_valid: got %b want 1", ifc.out_valid); end
        total++; if (ifc.bcd_out !== 16'h1234) begin bad++; $display("FAIL bp_first_bcd: got %h want 1234", ifc.bcd_out); end
        scan_digit(3, P5, 3);
        scan_digit(2, P6, 3);
        scan_digit(1, P7, 3);
        scan_digit(0, P8, 3);
        total++; if (ifc.overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun: got %b want 1", ifc.overrun); end
        total++; if (ifc.bcd_out !== 16'h1234) begin bad++; $display("FAIL bp_bcd_hold: got %h want 1234", ifc.bcd_out); end
        idle(1);
        total++; if (ovr_cnt - o0 !== 1) begin bad++; $display("FAIL bp_overrun_count: got %0d want 1", ovr_cnt - o0); end
        total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_hold: got %b want 1", ifc.out_valid); end
        ifc.out_ready = 1'b1;
        idle(1);
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_fall: got %b want 0", ifc.out_valid); end
    endtask

    task automatic test_blank;
        int e0;
        ifc.out_ready = 1'b1;
        e0 = err_cnt;
        scan_digit(3, PBLANK, 3);
        scan_digit(2, P5, 3);
        scan_digit(1, P6, 3);
        scan_digit(0, P7, 3);
`ifdef SEG7_BLANK_EN
        total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL blank_valid: got %b want 1", ifc.out_valid); end
        total++; if (ifc.bcd_out !== 16'hF567) begin bad++; $display("FAIL blank_bcd: got %h want f567", ifc.bcd_out); end
        idle(1);
        total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL blank_err: got %0d want 0", err_cnt - e0); end
`else
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL blank_valid: got %b want 0", ifc.out_valid); end
        idle(1);
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL blank_err: got %0d want 1", err_cnt - e0); end
        total++; if (dut.r_got !== 4'b0111) begin bad++; $display("FAIL blank_got: got %b want 0111", dut.r_got); end
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL blank_no_frame: got %b want 0", ifc.out_valid); end
`endif
    endtask

    task automatic test_reset_mid_frame;
        ifc.out_ready = 1'b0;
        scan_digit(3, P9, 3);
        scan_digit(2, P8, 3);
        scan_digit(1, P7, 3);
        scan_digit(0, P6, 3);
        total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL mid_pending: got %b want 1", ifc.out_valid); end
        scan_digit(3, P2, 3);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid_drop: got %b want 0", ifc.out_valid); end
        total++; if (ifc.bcd_out !== 16'h0000) begin bad++; $display("FAIL mid_bcd: got %h want 0000", ifc.bcd_out); end
        scan_digit(2, P3, 3);
        total++; if (dut.r_got !== 4'b0100) begin bad++; $display("FAIL mid_partial_dropped: got %b want 0100", dut.r_got); end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        err_cnt       = 0;
        ovr_cnt       = 0;
        rst_n         = 1'b0;
        ifc.sample    = 1'b0;
        ifc.seg       = 7'b0;
        ifc.dig_sel   = 4'b0;
        ifc.out_ready = 1'b0;
        test_reset();
        test_basic_scan();
        test_glitch();
        test_illegal();
        test_backpressure();
        test_blank();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
